// File: rtl/load_store_unit.sv
// Memory stage: turns an ALU effective address into a valid/ready data-memory
// transaction, stalls upstream while it is outstanding and returns extended load data.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        err_q, err_d;
    logic        ld_q, ld_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;

    logic        start, legal, misaligned, start_legal, start_err;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Request decode and legality checks on the incoming instruction.
    always_comb begin
        start = valid_in & (is_load | is_store) & (state_q == StIdle);
        if (is_load) begin
            legal = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010) |
                    (funct3 == 3'b100) | (funct3 == 3'b101);
        end else begin
            legal = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010);
        end
        misaligned = ((funct3[1:0] == 2'b01) & addr_in[0]) |
                     ((funct3[1:0] == 2'b10) & (addr_in[1:0] != 2'b00));
        start_legal = start & legal & ~misaligned;
        start_err   = start & ~(legal & ~misaligned);
        stall       = start_legal | (state_q == StReq);
    end

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << addr_in[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_strb  = 4'b0011 << addr_in[1:0];
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        err_d       = 1'b0;
        ld_d        = ld_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        case (state_q)
            StIdle: begin
                err_d = start_err;
                if (start_legal) begin
                    state_d     = StReq;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~is_load;
                    mem_addr_d  = {addr_in[31:2], 2'b00};
                    mem_wdata_d = is_load ? 32'h0 : st_wdata;
                    mem_wstrb_d = is_load ? 4'h0 : st_strb;
                    ld_d        = is_load;
                    funct3_d    = funct3;
                    off_d       = addr_in[1:0];
                    rd_d        = rd_in;
                end
            end
            StReq: begin
                if (mem_ready) begin
                    state_d     = StResp;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_wdata_d = 32'h0;
                    mem_wstrb_d = 4'h0;
                    wb_valid_d  = 1'b1;
                    wb_data_d   = ld_q ? ld_ext : 32'h0;
                    wb_rd_d     = ld_q ? rd_q : 5'd0;
                end
            end
            StResp: begin
                state_d   = StIdle;
                wb_data_d = 32'h0;
                wb_rd_d   = 5'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'h0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= 32'h0;
            wb_rd_q     <= 5'd0;
            err_q       <= 1'b0;
            ld_q        <= 1'b0;
            funct3_q    <= 3'b0;
            off_q       <= 2'b0;
            rd_q        <= 5'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            err_q       <= err_d;
            ld_q        <= ld_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign wb_rd     = wb_rd_q;
    assign err       = err_q;

endmodule
